// File: rtl/heap_cmd_sequencer.sv
// rtl/heap_cmd_sequencer.sv - command FIFO and one-at-a-time sequencer for a heap engine
// Purpose: queues push/pop commands, issues them in order to an external heap
//   engine, tracks heap occupancy and returns one status pulse per command.
//   Commands that would underflow or overflow the heap are rejected without
//   touching the engine.
// Ports:
//   clk, reset                      clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_key   command input (op 0=push, 1=pop)
//   heap_start/heap_op/heap_key/heap_done   heap engine handshake
//   rsp_valid/rsp_op/rsp_status      response pulse (00 ok, 01 empty, 10 full, 11 timeout)
//   count                           current heap occupancy
//   busy                            FSM active or commands queued
// Optional feature: define HEAP_CMD_TIMEOUT_EN to abandon WAIT after TIMEOUT_CYCLES.
module heap_cmd_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int HEAP_CAP       = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_key,
  output logic        heap_start,
  output logic        heap_op,
  output logic [31:0] heap_key,
  input  logic        heap_done,
  output logic        rsp_valid,
  output logic        rsp_op,
  output logic [1:0]  rsp_status,
  output logic [10:0] count,
  output logic        busy
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam logic [10:0] CAP = 11'(HEAP_CAP);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EMPTY   = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  logic [1:0]  state;
  logic        op_mem  [FIFO_DEPTH];
  logic [31:0] key_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        enq;
  logic        deq;
  logic        head_op;
  logic [31:0] head_key;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready depends only on registered state: a dequeue in RESP frees the
  // slot for the following cycle, never the current one.
  assign cmd_ready  = !fifo_full;
  assign enq        = cmd_valid && !fifo_full;
  assign deq        = (state == RESP);
  assign head_op    = op_mem[rd_ptr[AW-1:0]];
  assign head_key   = key_mem[rd_ptr[AW-1:0]];

  assign heap_start = (state == ISSUE);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (enq) begin
      op_mem[wr_ptr[AW-1:0]]  <= cmd_op;
      key_mem[wr_ptr[AW-1:0]] <= cmd_key;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef HEAP_CMD_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;

  // Counts cycles spent in WAIT; the last allowed cycle is TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end
  assign timed_out = (wait_cnt == TO_LAST);
`else
  logic timed_out;
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      heap_op    <= 1'b0;
      heap_key   <= '0;
      rsp_op     <= 1'b0;
      rsp_status <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            rsp_op <= head_op;
            if (head_op && count == 11'd0) begin
              rsp_status <= ST_EMPTY;
              state      <= RESP;
            end else if (!head_op && count == CAP) begin
              rsp_status <= ST_FULL;
              state      <= RESP;
            end else begin
              // Engine operands latch here and hold until the next issue.
              heap_op  <= head_op;
              heap_key <= head_key;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (heap_done) begin
            count      <= heap_op ? count - 11'd1 : count + 11'd1;
            rsp_status <= ST_OK;
            state      <= RESP;
          end else if (timed_out) begin
            rsp_status <= ST_TIMEOUT;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
